// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-port unified memory between the instruction-fetch path
// (read only) and the load/store data path (read or write) using a req/done handshake that
// hides the memory's multi-cycle latency.
//
// Ports:
//   Clk, Reset_signal              clock (rising edge), asynchronous active-high reset
//   if_req/if_addr                 fetch request (level, held until if_done) and address
//   if_done/if_rdata               one-cycle completion pulse and registered fetched word
//   d_req/d_we/d_addr/d_wdata      data request (level), write flag, address, store data
//   d_done/d_rdata                 one-cycle completion pulse and registered loaded word
//   mem_addr/mem_wdata/mem_wr      registered memory address, write data, write enable
//   mem_rdata                      memory read data
//   busy/owner/StateOut            not idle, current/last grantee (1 = data), encoded state
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned WR_LAT = 1
) (
  input  logic              Clk,
  input  logic              Reset_signal,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner,
  output logic [1:0]        StateOut
);

  if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
    $error("RD_LAT must be in 1..15");
  end
  if (WR_LAT < 1 || WR_LAT > 15) begin : g_bad_wr_lat
    $error("WR_LAT must be in 1..15");
  end

  localparam logic [3:0] RdCnt = 4'(RD_LAT - 1);
  localparam logic [3:0] WrCnt = 4'(WR_LAT - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                grant_data;
  logic                grant_we;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wr_d     = mem_wr_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    grant_data   = 1'b0;
    grant_we     = 1'b0;

    unique case (state_q)
      StIdle: begin
        mem_wr_d = 1'b0;
        if (if_req || d_req) begin
          // On a tie the side that did not win last time gets the port.
          grant_data   = d_req && (!if_req || !last_grant_q);
          grant_we     = grant_data && d_we;
          owner_d      = grant_data;
          last_grant_d = grant_data;
          mem_addr_d   = grant_data ? d_addr : if_addr;
          if (grant_data) begin
            mem_wdata_d = d_wdata;
          end
          mem_wr_d = grant_we;
          cnt_d    = grant_we ? WrCnt : RdCnt;
          state_d  = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          // mem_wr_q still tells us whether this access is a write.
          if (!mem_wr_q) begin
            if (owner_q) begin
              d_rdata_d = mem_rdata;
            end else begin
              if_rdata_d = mem_rdata;
            end
          end
          mem_wr_d = 1'b0;
          state_d  = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        mem_wr_d = 1'b0;
        state_d  = StIdle;
      end
      default: begin
        mem_wr_d = 1'b0;
        state_d  = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset_signal) begin
    if (Reset_signal) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wr_q     <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wr_q     <= mem_wr_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign if_done   = (state_q == StResp) && !owner_q;
  assign d_done    = (state_q == StResp) && owner_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr    = mem_wr_q;
  assign busy      = (state_q != StIdle);
  assign owner     = owner_q;
  assign StateOut  = state_q;

endmodule
